// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width,
// and the bit-counter width helper.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b), one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic fs_d;
    logic fs_bout;
    logic accept;
    logic last_bit;

    full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        accept   = 1'b0;
        last_bit = (cnt_q == CW'(WIDTH - 1));

        unique case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {fs_d, res_q[WIDTH-1:1]};
                br_d   = fs_bout;
                cnt_d  = cnt_q + CW'(1);
                // The port-visible result is only committed on the final bit.
                if (last_bit) begin
                    state_d = DONE;
                    diff_d  = {fs_d, res_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = RUN;
            a_sh_d  = a;
            b_sh_d  = b;
            res_d   = '0;
            br_d    = 1'b0;
            cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
`endif
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed literal cases plus
// randomized traffic compared every cycle against a timeline-based model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] diff;
    logic         bout, busy, done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an op accepted on edge e0 runs through edge e0+W and its result
    // appears (with done) after edge e0+W; accepts are refused while running.
    int           cyc = 0;
    bit           m_ready = 0;
    bit           m_active = 0;
    bit           m_running;
    int           m_e0 = 0;
    int           m_done_edge = -1;
    logic [W-1:0] m_res_d, exp_diff;
    logic         m_res_b, m_res_o, exp_bout, exp_ovf, exp_busy;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_ready  = 1;
            m_active = 0;
            exp_diff = '0;
            exp_bout = 1'b0;
            exp_ovf  = 1'b0;
        end else if (m_ready) begin
            m_running = m_active && (cyc <= m_e0 + W);
            if (m_active && cyc == m_e0 + W) begin
                exp_diff    = m_res_d;
                exp_bout    = m_res_b;
                exp_ovf     = m_res_o;
                m_active    = 0;
                m_done_edge = cyc;
            end
            if (start && !m_running) begin
                m_active = 1;
                m_e0     = cyc;
                m_res_d  = a - b;
                m_res_b  = (a < b);
                m_res_o  = (a[W-1] != b[W-1]) && (m_res_d[W-1] != a[W-1]);
            end
        end
        exp_busy = m_active;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("busy", busy, exp_busy);
            chk("done", done, m_done_edge == cyc);
            chk("diff", diff, exp_diff);
            chk("bout", bout, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", ovf, exp_ovf);
`endif
        end
    end

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done, 1'b1);
    endtask

    int n;
    int bc;
    logic [W-1:0] ra, rb;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        op(8'h55, 8'h33);
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_len", bc, 8);
        chk("d1_done", done, 1'b1);
        chk("d1_diff", diff, 8'h22);
        chk("d1_bout", bout, 1'b0);

        op(8'h33, 8'h55);
        wait_done(n);
        chk("d2_lat", n, 8);
        chk("d2_diff", diff, 8'hDE);
        chk("d2_bout", bout, 1'b1);

        op(8'h00, 8'h01);
        wait_done(n);
        chk("d3_diff", diff, 8'hFF);
        chk("d3_bout", bout, 1'b1);
        op(8'hA7, 8'hA7);
        wait_done(n);
        chk("d4_diff", diff, 8'h00);
        chk("d4_bout", bout, 1'b0);

        // start during RUN is ignored; start held in DONE re-accepts
        op(8'h55, 8'h33);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ign_diff", diff, 8'h22);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        n     = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 40);
        chk("b2b_gap", n, 9);
        chk("b2b_diff", diff, 8'hFF);
        chk("b2b_bout", bout, 1'b0);

        // reset mid-RUN aborts
        op(8'h55, 8'h33);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_diff", diff, 8'h00);
        op(8'h10, 8'h01);
        wait_done(n);
        chk("post_abort_diff", diff, 8'h0F);

`ifdef SERIAL_SUB_OVF_EN
        op(8'h80, 8'h01);
        wait_done(n);
        chk("ovf1_diff", diff, 8'h7F);
        chk("ovf1_ovf", ovf, 1'b1);
        chk("ovf1_bout", bout, 1'b0);
        op(8'h05, 8'h03);
        wait_done(n);
        chk("ovf0_diff", diff, 8'h02);
        chk("ovf0_ovf", ovf, 1'b0);
`endif

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 8'h00;
                1: ra = 8'hFF;
                2: ra = 8'h80;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: rb = 8'h00;
                1: rb = 8'hFF;
                2: rb = 8'h7F;
                default: rb = 8'($urandom);
            endcase
            a     = ra;
            b     = rb;
            start = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
